exp6_controle_exibicao: RTL and testbench

Sequencing controller that plays back the stored color sequence to the player before each response round. It walks the datapath sequence-memory address from 0 up to a requested limit and drives the LED display enable for a fixed on-time per item, with an optional dark gap between items. It sits beside the game control unit: the control unit pulses `iniciar`, waits for `pronto`, then enters its wait-for-move state.

---
 rtl/exp6_controle_exibicao.sv | 157 +++++++++++++++
 tb/tb_exp6_controle_exibicao.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/exp6_controle_exibicao.sv
// exp6_controle_exibicao
// Plays the stored color sequence back to the player: walks the sequence
// memory address from 0 up to a latched limit, holding the LED display
// enable for T_ON cycles per item, then pulses pronto for one cycle.
//
// Build option: define EXIBE_GAP_EN to build the dark-gap state (apaga),
// which inserts T_OFF cycles with the display off after every item so that
// repeated colors are visibly separated. Without it, acende goes straight
// to proximo and T_OFF is ignored.
module exp6_controle_exibicao #(
    parameter int ADDR_W = 4,
    parameter int T_ON   = 1000,
    parameter int T_OFF  = 250
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [ADDR_W-1:0] limite,
    output logic [ADDR_W-1:0] endereco,
    output logic              leds_en,
    output logic              ocupado,
    output logic              pronto,
    output logic [3:0]        db_estado
);

    // Timer must hold values up to max(T_ON, T_OFF) - 1; keep at least one bit.
    localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int TMR_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [TMR_W-1:0] ON_LAST = TMR_W'(T_ON - 1);

`ifdef EXIBE_GAP_EN
    localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(T_OFF - 1);

    typedef enum logic [3:0] {
        OCIOSO  = 4'h0,
        CARREGA = 4'h1,
        ACENDE  = 4'h2,
        APAGA   = 4'h3,
        PROXIMO = 4'h4,
        FIM     = 4'hF
    } estado_t;
`else
    typedef enum logic [3:0] {
        OCIOSO  = 4'h0,
        CARREGA = 4'h1,
        ACENDE  = 4'h2,
        PROXIMO = 4'h4,
        FIM     = 4'hF
    } estado_t;
`endif

    estado_t           estado;
    logic [TMR_W-1:0]  timer;
    logic [ADDR_W-1:0] lim_reg;

    // Sequencer FSM; Moore outputs are registered and set on entry to each state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado   <= OCIOSO;
            timer    <= '0;
            lim_reg  <= '0;
            endereco <= '0;
            leds_en  <= 1'b0;
            ocupado  <= 1'b0;
            pronto   <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (iniciar) begin
                        estado   <= CARREGA;
                        ocupado  <= 1'b1;
                        endereco <= '0;
                        timer    <= '0;
                    end
                end

                CARREGA: begin
                    // limite is captured here so later changes cannot affect this run
                    lim_reg  <= limite;
                    endereco <= '0;
                    timer    <= '0;
                    estado   <= ACENDE;
                    leds_en  <= 1'b1;
                end

                ACENDE: begin
                    if (timer == ON_LAST) begin
                        timer   <= '0;
                        leds_en <= 1'b0;
`ifdef EXIBE_GAP_EN
                        estado  <= APAGA;
`else
                        estado  <= PROXIMO;
`endif
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

`ifdef EXIBE_GAP_EN
                APAGA: begin
                    if (timer == OFF_LAST) begin
                        timer  <= '0;
                        estado <= PROXIMO;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
`endif

                PROXIMO: begin
                    // Compare before incrementing so the address never wraps
                    if (endereco == lim_reg) begin
                        estado  <= FIM;
                        ocupado <= 1'b0;
                        pronto  <= 1'b1;
                    end else begin
                        endereco <= endereco + 1'b1;
                        estado   <= ACENDE;
                        leds_en  <= 1'b1;
                    end
                end

                FIM: begin
                    // iniciar is deliberately not looked at here
                    pronto <= 1'b0;
                    estado <= OCIOSO;
                end

                default: begin
                    estado  <= OCIOSO;
                    timer   <= '0;
                    leds_en <= 1'b0;
                    ocupado <= 1'b0;
                    pronto  <= 1'b0;
                end
            endcase
        end
    end

    // Debug state code; any encoding outside the built state set reads as E.
    always_comb begin
        db_estado = 4'hE;
        case (estado)
            OCIOSO:  db_estado = 4'h0;
            CARREGA: db_estado = 4'h1;
            ACENDE:  db_estado = 4'h2;
`ifdef EXIBE_GAP_EN
            APAGA:   db_estado = 4'h3;
`endif
            PROXIMO: db_estado = 4'h4;
            FIM:     db_estado = 4'hF;
            default: db_estado = 4'hE;
        endcase
    end

endmodule

// File: tb/tb_exp6_controle_exibicao.sv
// Testbench for exp6_controle_exibicao (T_ON=4, T_OFF=2, ADDR_W=4).
// Works for both builds; the timing model follows EXIBE_GAP_EN.
module tb_exp6_controle_exibicao;

    localparam int AW   = 4;
    localparam int TON  = 4;
    localparam int TOFF = 2;
`ifdef EXIBE_GAP_EN
    localparam int P   = TON + TOFF + 1;
    localparam int GAP = 1;
`else
    localparam int P   = TON + 1;
    localparam int GAP = 0;
`endif

    logic          clock;
    logic          reset;
    logic          iniciar;
    logic [AW-1:0] limite;
    logic [AW-1:0] endereco;
    logic          leds_en;
    logic          ocupado;
    logic          pronto;
    logic [3:0]    db_estado;

    exp6_controle_exibicao #(.ADDR_W(AW), .T_ON(TON), .T_OFF(TOFF)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .limite    (limite),
        .endereco  (endereco),
        .leds_en   (leds_en),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: run flag, cycle index within run, latched limit.
    int cyc = 0;
    bit m_run = 0;
    int m_c = 0;
    int m_lim = 0;

    // Observation counters (DUT-derived).
    int leds_cnt = 0;
    int st3_cnt = 0;
    int occ_cnt = 0;
    int pr_cnt = 0;
    int last_pr_cyc = 0;
    int last_car_cyc = 0;
    int car_cnt = 0;
    logic [3:0] prev_st = 4'h0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model advance on a rising edge, from the timing rules (cycle arithmetic).
    task automatic model_step();
        if (reset) begin
            m_run = 0;
            m_c = 0;
            m_lim = 0;
        end else if (m_run) begin
            if (m_c == 0) m_lim = int'(limite);
            m_c++;
            if (m_c == (m_lim + 1) * P + 2) m_run = 0;
        end else if (iniciar) begin
            m_run = 1;
            m_c = 0;
        end
    endtask

    task automatic check_cycle();
        logic [3:0] st;
        logic le, oc, pr;
        int addr, k, r, n;
        bit achk;
        st = 4'h0; le = 1'b0; oc = 1'b0; pr = 1'b0; addr = 0; achk = 0;
        n = m_lim + 1;
        if (reset) begin
            achk = 1;
        end else if (m_run) begin
            if (m_c == 0) begin
                st = 4'h1; oc = 1'b1;
            end else if (m_c <= n * P) begin
                k = (m_c - 1) / P;
                r = (m_c - 1) % P;
                oc = 1'b1; addr = k; achk = 1;
                if (r < TON) begin
                    st = 4'h2; le = 1'b1;
                end else if (r < P - 1) begin
                    st = 4'h3;
                end else begin
                    st = 4'h4;
                end
            end else begin
                st = 4'hF; pr = 1'b1; addr = m_lim; achk = 1;
            end
        end
        n_cmp++;
        if (db_estado !== st || leds_en !== le || ocupado !== oc || pronto !== pr ||
            (achk && int'(endereco) != addr)) begin
            n_bad++;
            $display("FAIL cycle t=%0d: st=%h/%h leds=%b/%b ocup=%b/%b pronto=%b/%b end=%0d/%0d (got/expected)",
                     cyc, db_estado, st, leds_en, le, ocupado, oc, pronto, pr, endereco, addr);
        end
        if (leds_en) leds_cnt++;
        if (db_estado == 4'h3) st3_cnt++;
        if (ocupado) occ_cnt++;
        if (pronto) begin pr_cnt++; last_pr_cyc = cyc; end
        if (db_estado == 4'h1 && prev_st != 4'h1) begin car_cnt++; last_car_cyc = cyc; end
        prev_st = db_estado;
    endtask

    task automatic tick();
        @(posedge clock);
        cyc++;
        model_step();
        @(negedge clock);
        check_cycle();
    endtask

    task automatic wait_pronto(input int base, input string name);
        int b;
        b = 0;
        while (pr_cnt == base && b < 400) begin tick(); b++; end
        if (pr_cnt == base) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic run(input int lim, input int exp_pr, input int exp_leds,
                       input int exp_st3, input int exp_occ, input string name);
        int s, bl, b3, bo, bp;
        bl = leds_cnt; b3 = st3_cnt; bo = occ_cnt; bp = pr_cnt;
        limite = AW'(lim);
        iniciar = 1'b1;
        tick();
        s = cyc;
        iniciar = 1'b0;
        wait_pronto(bp, name);
        tick(); tick();
        chk({name, "_pronto_cycle"}, last_pr_cyc - s, exp_pr);
        chk({name, "_leds_cycles"}, leds_cnt - bl, exp_leds);
        chk({name, "_apaga_cycles"}, st3_cnt - b3, exp_st3);
        chk({name, "_ocupado_cycles"}, occ_cnt - bo, exp_occ);
    endtask

    initial begin
        int s, bp, bc;
        reset = 1'b1; iniciar = 1'b0; limite = '0;
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        chk("reset_idle_state", int'(db_estado), 0);

        // limite=3: pronto at cycle 29 (gap) / 21 (no gap)
        run(3, GAP ? 29 : 21, 16, GAP ? 8 : 0, GAP ? 29 : 21, "lim3");
        // limite=0: single item
        run(0, GAP ? 8 : 6, 4, GAP ? 2 : 0, GAP ? 8 : 6, "lim0");
        // limite=15: all 16 items, no wrap
        run(15, GAP ? 113 : 81, 64, GAP ? 32 : 0, GAP ? 113 : 81, "lim15");

        // Busy behaviour: limite/iniciar changes mid-run are ignored
        bp = pr_cnt; bc = car_cnt;
        limite = 4'd3;
        iniciar = 1'b1;
        tick();
        s = cyc;
        iniciar = 1'b0;
        while (cyc - s < 10) tick();
        limite = 4'd7;
        iniciar = 1'b1;
        while (cyc - s < 30) tick();
        tick();
        iniciar = 1'b0;
        chk("busy_pronto_cycle", last_pr_cyc - s, GAP ? 29 : 21);
        chk("busy_pronto_count", pr_cnt - bp, 1);
        chk("busy_restart_cycle", last_car_cyc - s, GAP ? 31 : 23);
        chk("busy_carrega_count", car_cnt - bc, 2);
        wait_pronto(bp + 1, "busy2");
        chk("busy2_pronto_cycle", last_pr_cyc - last_car_cyc, GAP ? 57 : 41);
        tick(); tick();

        // Asynchronous reset during acende
        limite = 4'd3;
        iniciar = 1'b1;
        tick();
        s = cyc;
        iniciar = 1'b0;
        while (cyc - s < 3) tick();
        chk("pre_reset_leds", int'(leds_en), 1);
        #1 reset = 1'b1;
        #1;
        chk("rst_leds_en", int'(leds_en), 0);
        chk("rst_ocupado", int'(ocupado), 0);
        chk("rst_pronto", int'(pronto), 0);
        chk("rst_endereco", int'(endereco), 0);
        chk("rst_db_estado", int'(db_estado), 0);
        model_step();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("post_reset_idle", int'(db_estado), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
